uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter clk_freq, default 50_000_000, meaning system clock in Hz.
REQ-002 SHALL have parameter baud_rate, default 9600, meaning line rate in bit/s.
REQ-003 SHALL have parameter MAX_BURST, default 16, meaning maximum bytes per grant, range 1..255.
REQ-004 SHALL have derived localparam TX_TIMEOUT = 12*(clk_freq/baud_rate), meaning cycles allowed per byte before abort.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  input  4  per-requester byte available.
REQ-008 SHALL have port req_data  input  32  byte of requester i on bits [8i+7:8i].
REQ-009 SHALL have port req_last  input  4  current byte of requester i ends its message.
REQ-010 SHALL have port req_ready  output  4  byte of requester i accepted this cycle.
REQ-011 SHALL have port tx_data  output  8  byte presented to transmitter.
REQ-012 SHALL have port tx_start  output  1  one-cycle launch pulse to transmitter.
REQ-013 SHALL have port tx_busy  input  1  transmitter currently shifting.
REQ-014 SHALL have port tx_done  input  1  one-cycle pulse, frame finished.
REQ-015 SHALL have port grant  output  4  one-hot current owner, 0 when idle.
REQ-016 SHALL have port err_timeout  output  1  one-cycle pulse on watchdog abort.

Function
REQ-017 SHALL implement states IDLE, GRANT, START, WAIT.
REQ-018 IDLE: if any req_valid, SHALL pick owner round-robin starting at (last_owner+1) mod 4, register grant, go GRANT next cycle; else stay.
REQ-019 GRANT: req_ready[g] SHALL be combinational = req_valid[g] & ~tx_busy; on that cycle SHALL capture req_data byte g into tx_data, capture req_last[g], increment burst_cnt, go START.
REQ-020 GRANT with req_valid[g] low SHALL release grant (grant=0, last_owner=g), go IDLE next cycle; no waiting on a silent owner.
REQ-021 GRANT with tx_busy high and req_valid[g] high SHALL hold, req_ready=0.
REQ-022 START: tx_start SHALL be 1 for exactly this one cycle, tx_data stable; go WAIT; watchdog cleared.
REQ-023 WAIT: watchdog SHALL count each cycle; on tx_done SHALL go GRANT if captured last=0 and burst_cnt<MAX_BURST, else release to IDLE.
REQ-024 WAIT: watchdog reaching TX_TIMEOUT-1 without tx_done SHALL pulse err_timeout one cycle, release grant, go IDLE.
REQ-025 tx_done and timeout in the same cycle: tx_done SHALL win, no err_timeout.
REQ-026 tx_done outside WAIT SHALL be ignored.
REQ-027 burst_cnt SHALL be 8-bit, cleared on each new grant from IDLE; grant release on burst_cnt==MAX_BURST even if req_last=0.
REQ-028 On release, last_owner SHALL update to the released requester; a sole active requester SHALL be re-granted after one IDLE cycle.
REQ-029 req_ready SHALL never assert outside GRANT and never for a non-owner; at most one bit high.
REQ-030 tx_data SHALL change only at capture in GRANT; held otherwise.
REQ-031 Latency: req_valid seen in IDLE at cycle N -> req_ready at N+1 (tx_busy=0) -> tx_start at N+2.

Reset
REQ-032 rst SHALL force state IDLE, grant=0, req_ready=0, tx_start=0, tx_data=0, err_timeout=0, burst_cnt=0, watchdog=0, last_owner=3 (first priority requester 0).
REQ-033 rst asserted mid-byte (START or WAIT) SHALL drop tx_start the next edge and discard the captured byte; no err_timeout.
REQ-034 rst SHALL dominate all other inputs in the same cycle.

Verification
REQ-035 After reset, req_valid=4'b1111 all req_last=1 -> grant order 0,1,2,3,0; one tx_start per grant.
REQ-036 Requester 2 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3), requester 0 valid throughout -> tx_data 0xA1,0xA2,0xA3 consecutive, then grant 0.
REQ-037 MAX_BURST=4, requester 1 streams 10 bytes req_last=0, requester 3 valid -> grant passes to 3 after 4th tx_done.
REQ-038 tx_done withheld after tx_start -> err_timeout pulse exactly TX_TIMEOUT cycles after START, grant=0 next cycle, next requester served.
REQ-039 tx_busy held high in GRANT for 20 cycles -> req_ready stays 0, then asserts the cycle tx_busy falls.
REQ-040 rst pulsed during WAIT -> all outputs at reset values next cycle; following arbitration starts at requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four byte streams share one UART transmitter.
// Each grant carries up to MAX_BURST bytes and is guarded by a per-byte watchdog.
module uart_tx_arbiter #(
  parameter int clk_freq  = 50_000_000,
  parameter int baud_rate = 9600,
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic [3:0]  grant,
  output logic        err_timeout,
  output logic [1:0]  state_dbg
);

  localparam int TX_TIMEOUT = 12 * (clk_freq / baud_rate);
  localparam int WD_W       = $clog2(TX_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t          r_state;
  logic [1:0]      r_owner;
  logic [1:0]      r_last_owner;
  logic [3:0]      r_grant;
  logic [7:0]      r_tx_data;
  logic            r_tx_start;
  logic            r_err;
  logic            r_last;
  logic [7:0]      r_burst_cnt;
  logic [WD_W-1:0] r_watchdog;

  logic [1:0]      w_pick;
  logic            w_owner_valid;
  logic            w_accept;
  logic            w_wd_expire;
  logic            w_more;

  // Lowest k wins, so the search starts just after the previous owner and
  // the previous owner itself is considered last.
  always_comb begin
    w_pick = r_last_owner;
    for (int k = 4; k >= 1; k--) begin
      if (req_valid[r_last_owner + 2'(k)]) w_pick = r_last_owner + 2'(k);
    end
  end

  // Handshake: a byte moves when req_valid[i] and req_ready[i] are both high
  // at a rising edge; req_ready is only ever offered to the owner in GRANT
  // while the transmitter is not busy, and valid may not depend on ready.
  assign w_owner_valid = req_valid[r_owner];
  assign w_accept      = (r_state == GRANT) && w_owner_valid && !tx_busy;
  assign w_wd_expire   = (r_watchdog == WD_W'(TX_TIMEOUT - 1));
  assign w_more        = !r_last && (r_burst_cnt < 8'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= 2'd0;
      r_last_owner <= 2'd3;
      r_grant      <= 4'b0000;
      r_tx_data    <= 8'h00;
      r_tx_start   <= 1'b0;
      r_err        <= 1'b0;
      r_last       <= 1'b0;
      r_burst_cnt  <= 8'd0;
      r_watchdog   <= '0;
    end else begin
      r_tx_start <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_owner     <= w_pick;
            r_grant     <= 4'b0001 << w_pick;
            r_burst_cnt <= 8'd0;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (!w_owner_valid) begin
            r_grant      <= 4'b0000;
            r_last_owner <= r_owner;
            r_state      <= IDLE;
          end else if (!tx_busy) begin
            r_tx_data   <= req_data[{r_owner, 3'b000} +: 8];
            r_last      <= req_last[r_owner];
            r_burst_cnt <= r_burst_cnt + 8'd1;
            r_watchdog  <= '0;
            r_tx_start  <= 1'b1;
            r_state     <= START;
          end
        end
        START: begin
          r_watchdog <= r_watchdog + WD_W'(1);
          r_state    <= WAIT;
        end
        WAIT: begin
          // A frame completing on the expiry cycle still counts as delivered.
          if (tx_done) begin
            if (w_more) begin
              r_state <= GRANT;
            end else begin
              r_grant      <= 4'b0000;
              r_last_owner <= r_owner;
              r_state      <= IDLE;
            end
          end else if (w_wd_expire) begin
            r_err        <= 1'b1;
            r_grant      <= 4'b0000;
            r_last_owner <= r_owner;
            r_state      <= IDLE;
          end else begin
            r_watchdog <= r_watchdog + WD_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready   = w_accept ? r_grant : 4'b0000;
  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign grant       = r_grant;
  assign err_timeout = r_err;
  assign state_dbg   = r_state;

endmodule
